uart_tx_scheduler: RTL

Shares one UART serial transmit line between two byte requesters using round-robin arbitration. Serializes each granted byte as an 8N1 frame (or 8N2), timed by the per-bit tx tick from the baud rate generator. Owns the generator's 16-bit baud divisor register and applies divisor changes only between frames. Sits between on-chip producers (core debug/console paths) and the baud rate generator / TX pin.

---
 rtl/uart_tx_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_scheduler
//  Purpose  : Round-robin arbiter between two byte requesters feeding a single
//             8N1/8N2 UART transmitter paced by an external per-bit tick.
//             Owns the baud divisor and defers divisor changes to idle time.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter logic [15:0] DEFAULT_DIV = 16'd868,
    parameter int          NUM_STOP    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        baud_div_wr_i,
    input  logic [15:0] baud_div_wdata_i,
    output logic [15:0] baud_div_o,
    output logic        div_pending_o,
    input  logic        tx_tick_i,
    input  logic        req0_valid_i,
    input  logic [7:0]  req0_data_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [7:0]  req1_data_i,
    output logic        req1_ready_o,
    output logic        tx_o,
    output logic        busy_o,
    output logic        grant_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Stop-bit counter value on which the last stop bit ends (one or two bits).
    localparam logic STOP_LAST = (NUM_STOP == 2);

    state_t      state_q,    state_d;
    logic        tx_q,       tx_d;
    logic        grant_q,    grant_d;
    logic        last_q,     last_d;
    logic [7:0]  data_q,     data_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic [15:0] baud_q,     baud_d;
    logic [15:0] shadow_q,   shadow_d;
    logic        pend_q,     pend_d;

    logic        wr_ok;
    logic        sel;
    logic        any_valid;
    logic        ready0;
    logic        ready1;

    // Arbitration choice: the sole requester, or on a tie the one not served last.
    always_comb begin
        wr_ok     = baud_div_wr_i && (baud_div_wdata_i != 16'd0);
        any_valid = req0_valid_i || req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            sel = ~last_q;
        end else begin
            sel = req1_valid_i;
        end
    end

    // Next-state, line and divisor logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        grant_d    = grant_q;
        last_d     = last_q;
        data_d     = data_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        baud_d     = baud_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        ready0     = 1'b0;
        ready1     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                // A fresh write wins over an older buffered value.
                if (wr_ok) begin
                    baud_d = baud_div_wdata_i;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    baud_d = shadow_q;
                    pend_d = 1'b0;
                end else if (any_valid && !rst_i) begin
                    ready0  = ~sel;
                    ready1  = sel;
                    data_d  = sel ? req1_data_i : req0_data_i;
                    grant_d = sel;
                    last_d  = sel;
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (tx_tick_i) begin
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tx_tick_i) begin
                    state_d   = ST_DATA;
                    tx_d      = data_q[0];
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (tx_tick_i) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d    = ST_STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = data_q[bit_cnt_q + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (tx_tick_i) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Mid-frame writes are parked; the generator keeps its divisor until idle.
        if ((state_q != ST_IDLE) && wr_ok) begin
            shadow_d = baud_div_wdata_i;
            pend_d   = 1'b1;
        end
    end

    // State and datapath registers; reset aborts any frame and pending divisor.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            data_q     <= 8'd0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            baud_q     <= DEFAULT_DIV;
            shadow_q   <= 16'd0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            data_q     <= data_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            baud_q     <= baud_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
        end
    end

    assign baud_div_o    = baud_q;
    assign div_pending_o = pend_q;
    assign req0_ready_o  = ready0;
    assign req1_ready_o  = ready1;
    assign tx_o          = tx_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign grant_o       = grant_q;

endmodule
`default_nettype wire
